// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns RISC-V memory ops into word-aligned valid/ready bus requests.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
package riscv_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } operation_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
    } rd_port_t;
endpackage

module lsu_bus_master
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  operation_e      operation_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            done_o,
    output rd_port_t        rd_port_o,
    output logic            misaligned_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_req_we_o,
    output logic [XLEN-1:0] mem_req_addr_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    output logic [3:0]      mem_req_be_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i
);
    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

    state_e          state_q, state_d;
    operation_e      op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic            req_valid_q, req_valid_d;
    logic            req_we_q, req_we_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]      req_be_q, req_be_d;
    rd_port_t        rd_port_q, rd_port_d;
    logic            misaligned_q, misaligned_d;

    logic            is_lsu, is_store, op_is_load_q;
    logic            accept, trap;
    logic [1:0]      off;
    logic [7:0]      rsp_byte;
    logic [15:0]     rsp_half;
    logic [XLEN-1:0] load_data;

    assign is_lsu       = operation_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    assign is_store     = operation_i inside {OP_SB, OP_SH, OP_SW};
    assign op_is_load_q = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

    // Offending low bits are dropped so the access behaves as its aligned neighbour.
    always_comb begin
        off = addr_i[1:0];
        if (operation_i inside {OP_LH, OP_LHU, OP_SH}) off[0] = 1'b0;
        if (operation_i inside {OP_LW, OP_SW})         off    = 2'b00;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((operation_i inside {OP_LH, OP_LHU, OP_SH}) && addr_i[0]) ||
                        ((operation_i inside {OP_LW, OP_SW}) && (addr_i[1:0] != 2'b00));
    assign accept = (state_q == IDLE) && req_valid_i && is_lsu && !misaligned;
    assign trap   = (state_q == IDLE) && req_valid_i && is_lsu && misaligned;
`else
    assign accept = (state_q == IDLE) && req_valid_i && is_lsu;
    assign trap   = 1'b0;
`endif

    assign rsp_byte = mem_rsp_data_i[{off_q, 3'b000} +: 8];
    assign rsp_half = mem_rsp_data_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        unique case (op_q)
            OP_LB:   load_data = {{(XLEN-8){rsp_byte[7]}}, rsp_byte};
            OP_LH:   load_data = {{(XLEN-16){rsp_half[15]}}, rsp_half};
            OP_LBU:  load_data = {{(XLEN-8){1'b0}}, rsp_byte};
            OP_LHU:  load_data = {{(XLEN-16){1'b0}}, rsp_half};
            default: load_data = mem_rsp_data_i;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        off_d           = off_q;
        rd_d            = rd_q;
        req_valid_d     = req_valid_q;
        req_we_d        = req_we_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_be_d        = req_be_q;
        rd_port_d       = rd_port_q;
        rd_port_d.valid = 1'b0;
        misaligned_d    = trap;
        done_o          = 1'b0;
        stall_o         = accept;

        unique case (state_q)
            IDLE: if (accept) begin
                state_d     = REQ;
                op_d        = operation_i;
                off_d       = off;
                rd_d        = rd_addr_i;
                req_valid_d = 1'b1;
                req_we_d    = is_store;
                req_addr_d  = {addr_i[XLEN-1:2], 2'b00};
                req_be_d    = 4'b1111;
                req_wdata_d = wdata_i;
                if (operation_i == OP_SB) begin
                    req_be_d    = 4'b0001 << off;
                    req_wdata_d = {4{wdata_i[7:0]}};
                end else if (operation_i == OP_SH) begin
                    req_be_d    = 4'b0011 << {off[1], 1'b0};
                    req_wdata_d = {2{wdata_i[15:0]}};
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem_req_ready_i) begin
                    req_valid_d = 1'b0;
                    // Stores are posted: no response phase.
                    state_d     = op_is_load_q ? RSP : DONE;
                end
            end
            RSP: begin
                stall_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    rd_port_d.addr  = rd_q;
                    rd_port_d.data  = load_data;
                    rd_port_d.valid = (rd_q != 5'd0);
                    state_d         = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            off_q        <= '0;
            rd_q         <= '0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            rd_port_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            req_valid_q  <= req_valid_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            rd_port_q    <= rd_port_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign mem_req_valid_o = req_valid_q;
    assign mem_req_we_o    = req_we_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wdata_o = req_wdata_q;
    assign mem_req_be_o    = req_be_q;
    assign rd_port_o       = rd_port_q;
    assign misaligned_o    = misaligned_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed table, hand sequences, random ops vs reference model.
module tb_lsu_bus_master;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    operation_e  operation_i = OP_NOP;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        stall_o, done_o, misaligned_o;
    rd_port_t    rd_port_o;
    logic        mem_req_valid_o, mem_req_we_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o;
    logic [3:0]  mem_req_be_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;

    always #5 clk_i = ~clk_i;

    lsu_bus_master #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .operation_i(operation_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .stall_o(stall_o), .done_o(done_o), .rd_port_o(rd_port_o), .misaligned_o(misaligned_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
    );

    typedef struct {
        operation_e  op;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic [31:0] rsp;
        int          rdy_wait, rsp_wait;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_data;
        logic        e_valid;
        int          e_stalls, e_done;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bit is_load(input operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    // Reference model: expected bus fields, load result and cycle counts from the ISA rules.
    function automatic vec_t model(input operation_e op, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [4:0] rd, input logic [31:0] rsp, input int rw, input int sw);
        vec_t v;
        int off, b, h;
        bit ld;
        ld = is_load(op);
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rsp = rsp;
        v.rdy_wait = rw; v.rsp_wait = sw;
        off = int'(addr % 4);
        if (op inside {OP_LH, OP_LHU, OP_SH}) off = off - (off % 2);
        if (op inside {OP_LW, OP_SW}) off = 0;
        v.e_addr  = addr - (addr % 4);
        v.e_be    = 4'hF;
        v.e_wdata = wdata;
        v.e_data  = 32'h0;
        b = int'((rsp >> (8 * off)) & 32'hFF);
        h = int'((rsp >> (8 * off)) & 32'hFFFF);
        case (op)
            OP_SB:  begin v.e_be = 4'(1 << off); v.e_wdata = (wdata & 32'hFF) * 32'h0101_0101; end
            OP_SH:  begin v.e_be = 4'(3 << off); v.e_wdata = (wdata & 32'hFFFF) * 32'h0001_0001; end
            OP_LB:  v.e_data = (b >= 128) ? 32'(b - 256) : 32'(b);
            OP_LH:  v.e_data = (h >= 32768) ? 32'(h - 65536) : 32'(h);
            OP_LBU: v.e_data = 32'(b);
            OP_LHU: v.e_data = 32'(h);
            OP_LW:  v.e_data = rsp;
            default: ;
        endcase
        v.e_valid  = ld && (rd != 5'd0);
        v.e_stalls = 2 + rw + (ld ? 1 + sw : 0);
        v.e_done   = ld ? 3 + rw + sw : 2 + rw;
        return v;
    endfunction

    // Presents one access, plays the bus responder, and checks everything seen up to DONE.
    task automatic apply_vec(input string tag, input vec_t v);
        int stalls = 0, done_cyc = -1, rdy_cnt = 0, rsp_cnt = 0, phase = 0;
        bit got = 0, unstable = 0, extra = 0, seen = 0, busy0 = 0, ld;
        logic [31:0] c_addr = '0, c_wdata = '0;
        logic [3:0]  c_be = '0;
        logic        c_we = 1'b0;
        rd_port_t    c_rd = '0;
        ld = is_load(v.op);
        for (int cyc = 0; cyc < 60 && !got; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) begin
                req_valid_i = 1'b1; operation_i = v.op; addr_i = v.addr;
                wdata_i = v.wdata; rd_addr_i = v.rd;
            end
            mem_req_ready_i = 1'b0;
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = $urandom;
            if (phase == 1) begin
                if (rsp_cnt >= v.rsp_wait) begin
                    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = v.rsp; phase = 2;
                end else rsp_cnt++;
            end
            #1;
            if (mem_req_valid_o) begin
                if (cyc == 0) busy0 = 1;
                if (phase != 0) extra = 1;
                else begin
                    if (!seen) begin
                        c_addr = mem_req_addr_o; c_be = mem_req_be_o;
                        c_wdata = mem_req_wdata_o; c_we = mem_req_we_o; seen = 1;
                    end else if (c_addr !== mem_req_addr_o || c_be !== mem_req_be_o ||
                                 c_wdata !== mem_req_wdata_o || c_we !== mem_req_we_o) unstable = 1;
                    if (rdy_cnt >= v.rdy_wait) begin
                        mem_req_ready_i = 1'b1; phase = ld ? 1 : 2;
                    end else rdy_cnt++;
                end
            end
            #1;
            if (stall_o) stalls++;
            if (done_o) begin got = 1; done_cyc = cyc; c_rd = rd_port_o; end
        end
        chk({tag, " done_seen"}, 64'(got), 64'd1);
        chk({tag, " stall_cycles"}, 64'(stalls), 64'(v.e_stalls));
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(v.e_done));
        chk({tag, " req_addr"}, 64'(c_addr), 64'(v.e_addr));
        chk({tag, " req_be"}, 64'(c_be), 64'(v.e_be));
        chk({tag, " req_we"}, 64'(c_we), 64'(!ld));
        chk({tag, " req_stable"}, 64'(unstable), 64'd0);
        chk({tag, " single_req"}, 64'(extra), 64'd0);
        chk({tag, " idle_at_accept"}, 64'(busy0), 64'd0);
        chk({tag, " rd_valid"}, 64'(c_rd.valid), 64'(v.e_valid));
        if (ld) begin
            chk({tag, " rd_data"}, 64'(c_rd.data), 64'(v.e_data));
            chk({tag, " rd_addr"}, 64'(c_rd.addr), 64'(v.rd));
        end else begin
            chk({tag, " req_wdata"}, 64'(c_wdata), 64'(v.e_wdata));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " bus_zero"}, 64'({mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_be_o}), 64'd0);
        chk({tag, " wdata_zero"}, 64'(mem_req_wdata_o), 64'd0);
        chk({tag, " ctl_zero"}, 64'({stall_o, done_o, misaligned_o}), 64'd0);
        chk({tag, " rd_port_zero"}, 64'(rd_port_o), 64'd0);
    endtask

    vec_t tbl[$];
    operation_e ops[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    initial begin
        // op, addr, wdata, rd, rsp, rdy_wait, rsp_wait, e_addr, e_be, e_wdata, e_data, e_valid, e_stalls, e_done
        tbl.push_back('{OP_LB,  32'h103,  32'h0,         5'd5,  32'h8000_0000, 0, 0, 32'h100,  4'hF, 32'h0,         32'hFFFF_FF80, 1'b1, 3, 3});
        tbl.push_back('{OP_SH,  32'h206,  32'h1234_ABCD, 5'd0,  32'h0,         2, 0, 32'h204,  4'hC, 32'hABCD_ABCD, 32'h0,         1'b0, 4, 4});
        tbl.push_back('{OP_LHU, 32'h10,   32'h0,         5'd0,  32'h0000_F00D, 0, 0, 32'h10,   4'hF, 32'h0,         32'h0000_F00D, 1'b0, 3, 3});
        tbl.push_back('{OP_SB,  32'h101,  32'hFFFF_FF55, 5'd0,  32'h0,         1, 0, 32'h100,  4'h2, 32'h5555_5555, 32'h0,         1'b0, 3, 3});
        tbl.push_back('{OP_LH,  32'h2,    32'h0,         5'd3,  32'h8001_0000, 0, 2, 32'h0,    4'hF, 32'h0,         32'hFFFF_8001, 1'b1, 5, 5});
        tbl.push_back('{OP_LBU, 32'h3003, 32'h0,         5'd31, 32'h9A00_0000, 1, 1, 32'h3000, 4'hF, 32'h0,         32'h0000_009A, 1'b1, 5, 5});
        tbl.push_back('{OP_SW,  32'h40,   32'hCAFE_F00D, 5'd0,  32'h0,         0, 0, 32'h40,   4'hF, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 2});
        tbl.push_back('{OP_LW,  32'h44,   32'h0,         5'd1,  32'h7654_3210, 0, 0, 32'h44,   4'hF, 32'h0,         32'h7654_3210, 1'b1, 3, 3});
        tbl.push_back('{OP_SB,  32'h13,   32'h0000_00AB, 5'd0,  32'h0,         0, 0, 32'h10,   4'h8, 32'hABAB_ABAB, 32'h0,         1'b0, 2, 2});
        tbl.push_back('{OP_LB,  32'h21,   32'h0,         5'd2,  32'h0000_7F00, 0, 0, 32'h20,   4'hF, 32'h0,         32'h0000_007F, 1'b1, 3, 3});
`ifndef LSU_MISALIGN_TRAP_EN
        tbl.push_back('{OP_LH,  32'h3,    32'h0,         5'd6,  32'h1234_5678, 0, 0, 32'h0,    4'hF, 32'h0,         32'h0000_1234, 1'b1, 3, 3});
        tbl.push_back('{OP_SW,  32'h47,   32'h0BAD_CAFE, 5'd0,  32'h0,         0, 0, 32'h44,   4'hF, 32'h0BAD_CAFE, 32'h0,         1'b0, 2, 2});
`endif

        repeat (3) @(negedge clk_i);
        #1 check_all_zero("reset");
        @(negedge clk_i) rst_i = 1'b0;

        foreach (tbl[i]) apply_vec($sformatf("tbl%0d", i), tbl[i]);

        // Reset while waiting for a load response; the late response must be dropped.
        @(negedge clk_i);
        req_valid_i = 1'b1; operation_i = OP_LW; addr_i = 32'h80; rd_addr_i = 5'd4;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
        @(negedge clk_i) mem_req_ready_i = 1'b1;
        @(negedge clk_i) mem_req_ready_i = 1'b0;
        #1 chk("rst_seq stall_in_rsp", 64'(stall_o), 64'd1);
        rst_i = 1'b1; req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1111_2222;
        #1 check_all_zero("after_rst");
        @(negedge clk_i) mem_rsp_valid_i = 1'b0;
        #1 chk("rst_seq late_rsp_done", 64'(done_o), 64'd0);
        chk("rst_seq late_rsp_rd", 64'(rd_port_o), 64'd0);
        apply_vec("post_rst_lw", model(OP_LW, 32'h80, 32'h0, 5'd4, 32'h600D_F00D, 0, 0));

        // Spurious response and a non-memory op while idle.
        @(negedge clk_i);
        req_valid_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = $urandom;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0; req_valid_i = 1'b1; operation_i = OP_ADD;
        #1 chk("spurious done", 64'(done_o), 64'd0);
        chk("spurious rd_valid", 64'(rd_port_o.valid), 64'd0);
        chk("nonlsu stall", 64'(stall_o), 64'd0);
        @(negedge clk_i) req_valid_i = 1'b0;
        #1 chk("nonlsu no_req", 64'(mem_req_valid_o), 64'd0);
        apply_vec("b2b_lw", model(OP_LW, 32'h500, 32'h0, 5'd9, 32'h0102_0304, 1, 0));
        apply_vec("b2b_sw", model(OP_SW, 32'h504, 32'hFEED_BEEF, 5'd0, 32'h0, 0, 0));

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk_i);
        req_valid_i = 1'b1; operation_i = OP_LW; addr_i = 32'h102; rd_addr_i = 5'd9;
        #1 chk("mis stall", 64'(stall_o), 64'd0);
        @(negedge clk_i) req_valid_i = 1'b0;
        #1 chk("mis pulse", 64'(misaligned_o), 64'd1);
        chk("mis no_req", 64'(mem_req_valid_o), 64'd0);
        @(negedge clk_i);
        #1 chk("mis pulse_end", 64'(misaligned_o), 64'd0);
        chk("mis no_done", 64'({done_o, rd_port_o.valid, mem_req_valid_o}), 64'd0);
`else
        apply_vec("lw_mis", model(OP_LW, 32'h102, 32'h0, 5'd9, 32'hA5A5_5A5A, 0, 0));
        chk("lw_mis flag", 64'(misaligned_o), 64'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            operation_e op;
            logic [31:0] a;
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            if (op inside {OP_LH, OP_LHU, OP_SH}) a[0] = 1'b0;
            if (op inside {OP_LW, OP_SW}) a[1:0] = 2'b00;
`endif
            apply_vec($sformatf("rnd%0d", i),
                      model(op, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3)));
        end

        @(negedge clk_i) req_valid_i = 1'b0;
        #1 chk("final idle stall", 64'({stall_o, mem_req_valid_o}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
